// File: rtl/inp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inp_ctrl (with helper inp_ctrl_debounce)
//  Brief    : Input-side controller. Synchronises and debounces the switch
//             bank and the exec button, generates a one-cycle exec strobe,
//             and answers processor input reads over a req/ack handshake
//             that waits for the user to confirm with an exec press.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  inp_ctrl_debounce
//  Two-flop synchroniser followed by a group debounce filter. A new value
//  must remain unchanged on the synchronised side for DB_LIMIT cycles before
//  it is passed to the output. The counter saturates so it never wraps.
// ----------------------------------------------------------------------------
module inp_ctrl_debounce #(
    parameter int W        = 16,
    parameter int DB_LIMIT = 50000,
    parameter int DB_W     = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] din_raw,
    output logic [W-1:0] dout
);

    // Counter end points. The output is loaded on the transition into
    // DB_LIMIT-1, i.e. while the counter currently holds DB_LIMIT-2.
    localparam logic [DB_W-1:0] C_CNT_MAX = DB_W'(DB_LIMIT);
    localparam logic [DB_W-1:0] C_CNT_PRE = DB_W'(DB_LIMIT - 2);

    logic [W-1:0]    sync1_q, sync1_d;
    logic [W-1:0]    sync2_q, sync2_d;
    logic [W-1:0]    cand_q,  cand_d;
    logic [DB_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]    out_q,   out_d;

    // Next-state: synchroniser shift and debounce candidate/counter update.
    always_comb begin
        sync1_d = din_raw;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (sync2_q != cand_q) begin
            // Input moved: restart the stability window on the new value.
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + DB_W'(1);
            if (cnt_q == C_CNT_PRE) begin
                out_d = cand_q;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign dout = out_q;

endmodule

// ----------------------------------------------------------------------------
//  inp_ctrl (top)
// ----------------------------------------------------------------------------
module inp_ctrl #(
    parameter int WIDTH    = 16,
    parameter int DB_LIMIT = 50000,
    parameter int DB_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    input  logic             in_req,
    output logic             in_ack,
    output logic [WIDTH-1:0] in_data,
    output logic             exec,
    output logic [WIDTH-1:0] sw_live,
    output logic             waiting
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] in_data_q, in_data_d;
    logic             exec_q, exec_d;
    logic             btn_db_prev_q, btn_db_prev_d;
    logic [WIDTH-1:0] sw_db;
    logic             btn_db;
    logic             exec_pulse;

    inp_ctrl_debounce #(
        .W        (WIDTH),
        .DB_LIMIT (DB_LIMIT),
        .DB_W     (DB_W)
    ) u_sw_db (
        .clock   (clock),
        .reset   (reset),
        .din_raw (sw),
        .dout    (sw_db)
    );

    inp_ctrl_debounce #(
        .W        (1),
        .DB_LIMIT (DB_LIMIT),
        .DB_W     (DB_W)
    ) u_btn_db (
        .clock   (clock),
        .reset   (reset),
        .din_raw (btn),
        .dout    (btn_db)
    );

    // Rising edge of the debounced button: one pulse per accepted press.
    assign exec_pulse = btn_db & ~btn_db_prev_q;

    // Handshake FSM and exec forwarding. Only the ACK entry path writes
    // in_data; a press consumed by a read is never forwarded as exec.
    always_comb begin
        state_d       = state_q;
        in_data_d     = in_data_q;
        exec_d        = 1'b0;
        btn_db_prev_d = btn_db;
        case (state_q)
            ST_IDLE: begin
                if (in_req) begin
                    if (exec_pulse) begin
                        in_data_d = sw_db;
                        state_d   = ST_ACK;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end else begin
                    exec_d = exec_pulse;
                end
            end
            ST_WAIT: begin
                // A withdrawn request wins over a coincident press.
                if (!in_req) begin
                    state_d = ST_IDLE;
                end else if (exec_pulse) begin
                    in_data_d = sw_db;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!in_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and output registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            in_data_q     <= '0;
            exec_q        <= 1'b0;
            btn_db_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_data_q     <= in_data_d;
            exec_q        <= exec_d;
            btn_db_prev_q <= btn_db_prev_d;
        end
    end

    // in_ack and waiting decode straight from the state so an asynchronous
    // reset removes them immediately.
    assign in_ack  = (state_q == ST_ACK);
    assign waiting = (state_q == ST_WAIT);
    assign in_data = in_data_q;
    assign exec    = exec_q;
    assign sw_live = sw_db;

endmodule

`default_nettype wire

// File: tb/tb_inp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inp_ctrl
//  Brief    : Directed self-checking bench for inp_ctrl with DB_LIMIT=4.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inp_ctrl;

    localparam int C_WIDTH    = 16;
    localparam int C_DB_LIMIT = 4;
    localparam int C_DB_W     = 8;

    logic               clock;
    logic               reset;
    logic [C_WIDTH-1:0] sw;
    logic               btn;
    logic               in_req;
    logic               in_ack;
    logic [C_WIDTH-1:0] in_data;
    logic               exec;
    logic [C_WIDTH-1:0] sw_live;
    logic               waiting;

    int n_checks;
    int n_errors;

    inp_ctrl #(
        .WIDTH    (C_WIDTH),
        .DB_LIMIT (C_DB_LIMIT),
        .DB_W     (C_DB_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .sw      (sw),
        .btn     (btn),
        .in_req  (in_req),
        .in_ack  (in_ack),
        .in_data (in_data),
        .exec    (exec),
        .sw_live (sw_live),
        .waiting (waiting)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int exec_cnt, ack_cnt, first_exec, first_ack;
    logic [C_WIDTH-1:0] ack_data;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset  = 1'b1;
        sw     = '0;
        btn    = 1'b0;
        in_req = 1'b0;

        // ---- Reset state ------------------------------------------------
        tick(); tick();
        check("rst_sw_live", 32'(sw_live), 32'h0);
        check("rst_in_data", 32'(in_data), 32'h0);
        check("rst_ctl",     32'({in_ack, exec, waiting}), 32'h0);

        // ---- First switch value: appears on cycle 6 ---------------------
        reset = 1'b0;
        sw    = 16'h1234;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("sw_latency_hold", 32'(sw_live), 32'h0);
        end
        tick();
        check("sw_latency_load", 32'(sw_live), 32'h1234);

        // ---- Chatter on the switches never reaches sw_live --------------
        for (int r = 0; r < 3; r++) begin
            sw = 16'h00FF;
            tick(); check("sw_chatter", 32'(sw_live), 32'h1234);
            tick(); check("sw_chatter", 32'(sw_live), 32'h1234);
            sw = 16'h0000;
            tick(); check("sw_chatter", 32'(sw_live), 32'h1234);
            tick(); check("sw_chatter", 32'(sw_live), 32'h1234);
        end
        sw = 16'h00FF;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("sw_settle_hold", 32'(sw_live), 32'h1234);
        end
        tick();
        check("sw_settle_load", 32'(sw_live), 32'h00FF);

        // ---- Bouncing button then a clean hold: one exec pulse ----------
        exec_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            btn = 1'b1; tick(); if (exec) exec_cnt++;
            btn = 1'b0; tick(); if (exec) exec_cnt++;
        end
        check("btn_bounce_no_exec", 32'(exec_cnt), 32'd0);
        btn = 1'b1;
        exec_cnt   = 0;
        first_exec = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (exec) begin
                exec_cnt++;
                if (first_exec == 0) first_exec = i;
            end
        end
        check("btn_exec_count", 32'(exec_cnt), 32'd1);
        check("btn_exec_cycle", 32'(first_exec), 32'd7);
        btn = 1'b0;
        exec_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (exec) exec_cnt++;
        end
        check("btn_release_no_exec", 32'(exec_cnt), 32'd0);

        // ---- Full read handshake ----------------------------------------
        sw = 16'hBEEF;
        for (int i = 0; i < 8; i++) tick();
        check("read_sw_live", 32'(sw_live), 32'hBEEF);
        in_req = 1'b1;
        tick();
        check("read_waiting", 32'(waiting), 32'd1);
        check("read_no_ack",  32'(in_ack),  32'd0);
        btn = 1'b1;
        ack_cnt = 0; exec_cnt = 0; first_ack = 0; ack_data = '0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (exec) exec_cnt++;
            if (in_ack) begin
                ack_cnt++;
                ack_data = in_data;
                if (first_ack == 0) first_ack = i;
            end
        end
        check("read_ack_count", 32'(ack_cnt),   32'd1);
        check("read_ack_cycle", 32'(first_ack), 32'd7);
        check("read_ack_data",  32'(ack_data),  32'hBEEF);
        check("read_no_exec",   32'(exec_cnt),  32'd0);
        check("read_hold_wait", 32'(waiting),   32'd0);
        in_req = 1'b0;
        tick();
        check("read_idle_wait", 32'(waiting), 32'd0);
        check("read_idle_ack",  32'(in_ack),  32'd0);
        btn = 1'b0;
        exec_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (exec) exec_cnt++;
        end
        check("read_release_no_exec", 32'(exec_cnt), 32'd0);

        // ---- Request withdrawn before a press ---------------------------
        sw = 16'h1111;
        for (int i = 0; i < 8; i++) tick();
        in_req = 1'b1;
        tick();
        check("abort_waiting", 32'(waiting), 32'd1);
        tick(); tick();
        in_req = 1'b0;
        tick();
        check("abort_idle", 32'(waiting), 32'd0);
        ack_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (in_ack) ack_cnt++;
        end
        check("abort_no_ack",  32'(ack_cnt), 32'd0);
        check("abort_in_data", 32'(in_data), 32'hBEEF);
        btn = 1'b1;
        exec_cnt = 0; ack_cnt = 0; first_exec = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (in_ack) ack_cnt++;
            if (exec) begin
                exec_cnt++;
                if (first_exec == 0) first_exec = i;
            end
        end
        check("abort_exec_count", 32'(exec_cnt),   32'd1);
        check("abort_exec_cycle", 32'(first_exec), 32'd7);
        check("abort_ack_none",   32'(ack_cnt),    32'd0);
        btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // ---- Asynchronous reset in WAIT ---------------------------------
        in_req = 1'b1;
        tick();
        btn = 1'b1;
        tick(); tick(); tick();
        check("areset_pre_wait", 32'(waiting), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_ctl",     32'({in_ack, exec, waiting}), 32'h0);
        check("areset_sw_live", 32'(sw_live), 32'h0);
        check("areset_in_data", 32'(in_data), 32'h0);
        in_req = 1'b0;
        btn    = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("areset_sw_hold", 32'(sw_live), 32'h0);
        end
        tick();
        check("areset_sw_load", 32'(sw_live), 32'h1111);
        in_req = 1'b1;
        tick();
        check("areset_idle_to_wait", 32'(waiting), 32'd1);
        in_req = 1'b0;
        tick();
        check("areset_back_idle", 32'(waiting), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
